// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port variable-latency memory between IF and MEM requesters
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   output logic              if_stall,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_valid,
   output logic              mem_stall,
   output logic              ram_cs,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   input  logic              ram_ack,
   output logic              err
);
   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;
   state_t     state, nxt;
   logic       last_mem, flushed, if_ok, mem_ok, busy, grant_if, grant_mem, done, expire;
   logic [7:0] cnt;
   assign if_stall  = if_req & ~if_valid;
   assign mem_stall = mem_req & ~mem_valid;
   // arbitration and end of transaction; a requester is ineligible in its own valid cycle because that request was just served
   always_comb begin
      if_ok     = if_req & ~if_valid;
      mem_ok    = mem_req & ~mem_valid;
      busy      = state != IDLE;
      grant_mem = ~busy & mem_ok & (~if_ok | ~last_mem);
      grant_if  = ~busy & if_ok & ~grant_mem;
      done      = busy & ram_ack;
      expire    = busy & ~ram_ack & (cnt == 8'(TIMEOUT - 1));
      nxt       = grant_mem ? BUSY_MEM : grant_if ? BUSY_IF : (done | expire) ? IDLE : state;
   end
   // state register
   always_ff @(posedge clk) state <= rst ? IDLE : nxt;
   // memory port, timeout counter and registered results
   always_ff @(posedge clk) begin
      if (rst) begin
         last_mem  <= 1'b0;
         flushed   <= 1'b0;
         cnt       <= '0;
         ram_cs    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         if_rdata  <= '0;
         mem_rdata <= '0;
         if_valid  <= 1'b0;
         mem_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         if_valid  <= 1'b0;
         mem_valid <= 1'b0;
         if (grant_if | grant_mem) begin
            ram_cs   <= 1'b1;
            ram_we   <= grant_mem & mem_we;
            ram_addr <= grant_mem ? mem_addr : if_addr;
            if (grant_mem) ram_wdata <= mem_wdata;
            last_mem <= grant_mem;
            flushed  <= 1'b0;
            cnt      <= '0;
         end
         if (busy) begin
            cnt <= cnt + 8'd1;
            if (state == BUSY_IF && !if_req) flushed <= 1'b1;
         end
         if (done | expire) begin
            ram_cs <= 1'b0;
            ram_we <= 1'b0;
            cnt    <= '0;
            err    <= err | expire;
            if (state == BUSY_IF && if_req && !flushed) begin
               if_valid <= 1'b1;
               if_rdata <= done ? ram_rdata : '0;
            end
            if (state == BUSY_MEM) begin
               mem_valid <= 1'b1;
               if (expire || !ram_we) mem_rdata <= done ? ram_rdata : '0;
            end
         end
      end
   end
endmodule
